// File: rtl/param_sync_fifo.sv
// Single-clock circular-buffer FIFO with registered (FWFT=0, 1-cycle read latency) or fall-through (FWFT=1, 0-cycle) read.
// No backpressure: a write while full or a read while empty is dropped and latched in sticky overflow/underflow.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AEMPTY     = 3,
  parameter int AFULL      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ack,
  input  logic                  read_req,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  rdata_valid,
  output logic                  fifo_empty,
  output logic                  fifo_aempty,
  output logic                  fifo_full,
  output logic                  fifo_afull,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH+1)'(AEMPTY);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(DEPTH - AFULL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0] rd_ptr_nxt;
  logic                wr_en;
  logic                rd_en;

  // Flags come straight off the registered level so they move with it.
  assign fifo_empty  = (fill_level == '0);
  assign fifo_full   = (fill_level == FULL_LVL);
  assign fifo_aempty = (fill_level <= AE_LVL);
  assign fifo_afull  = (fill_level >= AF_LVL);

  assign wr_en = wdata_valid & ~fifo_full  & ~flush;
  assign rd_en = read_req    & ~fifo_empty & ~flush;

  assign wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
  assign rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      write_ack  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      write_ack  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      // Extra pointer MSB makes the modular difference span 0..DEPTH.
      fill_level <= wr_ptr_nxt - rd_ptr_nxt;
      write_ack  <= wr_en;
      if (wdata_valid && fifo_full)
        overflow <= 1'b1;
      if (read_req && fifo_empty)
        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      always_ff @(posedge clk) begin
        if (reset) begin
          read_data   <= '0;
          rdata_valid <= 1'b0;
        end else if (flush) begin
          rdata_valid <= 1'b0;
        end else begin
          rdata_valid <= rd_en;
          if (rd_en)
            read_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end
    end else begin : g_fwft_read
      // Head word is always on the bus; read_req just retires it.
      assign read_data   = mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign rdata_valid = ~fifo_empty;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: registered-read FIFO at defaults plus a fall-through instance sharing clk/reset.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        reset;
  int          vectors = 0;
  int          miscompares = 0;

  logic        flush, wdata_valid, read_req;
  logic [15:0] write_data;
  logic        write_ack, rdata_valid, fifo_empty, fifo_aempty, fifo_full, fifo_afull;
  logic [15:0] read_data;
  logic [4:0]  fill_level;
  logic        overflow, underflow;

  logic        f_flush, f_wvalid, f_rreq;
  logic [15:0] f_wdata;
  logic        f_wack, f_rvalid, f_empty, f_aempty, f_full, f_afull;
  logic [15:0] f_rdata;
  logic [4:0]  f_level;
  logic        f_ovf, f_unf;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AEMPTY(3), .AFULL(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wdata_valid(wdata_valid), .write_data(write_data), .write_ack(write_ack),
    .read_req(read_req), .read_data(read_data), .rdata_valid(rdata_valid),
    .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty), .fifo_full(fifo_full),
    .fifo_afull(fifo_afull), .fill_level(fill_level),
    .overflow(overflow), .underflow(underflow)
  );

  param_sync_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AEMPTY(3), .AFULL(3)) dut_fwft (
    .clk(clk), .reset(reset), .flush(f_flush),
    .wdata_valid(f_wvalid), .write_data(f_wdata), .write_ack(f_wack),
    .read_req(f_rreq), .read_data(f_rdata), .rdata_valid(f_rvalid),
    .fifo_empty(f_empty), .fifo_aempty(f_aempty), .fifo_full(f_full),
    .fifo_afull(f_afull), .fill_level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".level"},  32'(fill_level), 32'd0);
    check({tag, ".empty"},  32'(fifo_empty), 32'd1);
    check({tag, ".aempty"}, 32'(fifo_aempty), 32'd1);
    check({tag, ".full"},   32'(fifo_full), 32'd0);
    check({tag, ".afull"},  32'(fifo_afull), 32'd0);
    check({tag, ".wack"},   32'(write_ack), 32'd0);
    check({tag, ".rvalid"}, 32'(rdata_valid), 32'd0);
    check({tag, ".ovf"},    32'(overflow), 32'd0);
    check({tag, ".unf"},    32'(underflow), 32'd0);
    check({tag, ".rdata"},  32'(read_data), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wdata_valid = 1'b0; read_req = 1'b0; write_data = '0;
    f_flush = 1'b0; f_wvalid = 1'b0; f_rreq = 1'b0; f_wdata = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");
    check("fwft.reset_empty", 32'(f_empty), 32'd1);
    check("fwft.reset_rvalid", 32'(f_rvalid), 32'd0);

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      wdata_valid = 1'b1; write_data = 16'(i);
      tick();
      check($sformatf("fill.wack%0d", i), 32'(write_ack), 32'd1);
      check($sformatf("fill.level%0d", i), 32'(fill_level), 32'(i));
      check($sformatf("fill.afull%0d", i), 32'(fifo_afull), (i >= 13) ? 32'd1 : 32'd0);
      check($sformatf("fill.full%0d", i), 32'(fifo_full), (i == 16) ? 32'd1 : 32'd0);
    end
    write_data = 16'hDEAD;
    tick();
    check("ovf17.wack", 32'(write_ack), 32'd0);
    check("ovf17.ovf", 32'(overflow), 32'd1);
    check("ovf17.level", 32'(fill_level), 32'd16);
    wdata_valid = 1'b0;

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      read_req = 1'b1;
      tick();
      read_req = 1'b0;
      check($sformatf("drain.rvalid%0d", i), 32'(rdata_valid), 32'd1);
      check($sformatf("drain.data%0d", i), 32'(read_data), 32'(i));
      check($sformatf("drain.level%0d", i), 32'(fill_level), 32'(16 - i));
      check($sformatf("drain.aempty%0d", i), 32'(fifo_aempty), (16 - i <= 3) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("drain.vpulse%0d", i), 32'(rdata_valid), 32'd0);
      check($sformatf("drain.hold%0d", i), 32'(read_data), 32'(i));
    end
    check("drain.empty", 32'(fifo_empty), 32'd1);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    check("unf.rvalid", 32'(rdata_valid), 32'd0);
    check("unf.unf", 32'(underflow), 32'd1);
    check("unf.ovf_sticky", 32'(overflow), 32'd1);
    check("unf.hold", 32'(read_data), 32'h0010);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush1.ovf", 32'(overflow), 32'd0);
    check("flush1.unf", 32'(underflow), 32'd0);
    check("flush1.level", 32'(fill_level), 32'd0);

    // Wrap: 3 x (10 writes then 10 reads)
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 10; j++) begin
        wdata_valid = 1'b1; write_data = 16'(16'h0100 * (r + 1) + j);
        tick();
        check($sformatf("wrap%0d.level_w%0d", r, j), 32'(fill_level), 32'(j + 1));
      end
      wdata_valid = 1'b0;
      for (int j = 0; j < 10; j++) begin
        read_req = 1'b1;
        tick();
        check($sformatf("wrap%0d.data%0d", r, j), 32'(read_data), 32'(16'h0100 * (r + 1) + j));
        check($sformatf("wrap%0d.level_r%0d", r, j), 32'(fill_level), 32'(9 - j));
      end
      read_req = 1'b0;
    end
    check("wrap.ovf", 32'(overflow), 32'd0);

    // Full with simultaneous read+write: read wins, write rejected
    for (int i = 0; i < 16; i++) begin
      wdata_valid = 1'b1; write_data = 16'(16'h0200 + i);
      tick();
    end
    check("fullrw.pre_full", 32'(fifo_full), 32'd1);
    read_req = 1'b1; write_data = 16'hBEEF;
    tick();
    wdata_valid = 1'b0; read_req = 1'b0;
    check("fullrw.wack", 32'(write_ack), 32'd0);
    check("fullrw.ovf", 32'(overflow), 32'd1);
    check("fullrw.rvalid", 32'(rdata_valid), 32'd1);
    check("fullrw.data", 32'(read_data), 32'h0200);
    check("fullrw.level", 32'(fill_level), 32'd15);

    // Mid-level simultaneous read+write keeps the level
    wdata_valid = 1'b1; read_req = 1'b1; write_data = 16'h0300;
    tick();
    wdata_valid = 1'b0; read_req = 1'b0;
    check("midrw.level", 32'(fill_level), 32'd15);
    check("midrw.data", 32'(read_data), 32'h0201);
    check("midrw.wack", 32'(write_ack), 32'd1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    // Empty with simultaneous read+write: write wins, read rejected
    wdata_valid = 1'b1; read_req = 1'b1; write_data = 16'h0055;
    tick();
    wdata_valid = 1'b0; read_req = 1'b0;
    check("emptyrw.level", 32'(fill_level), 32'd1);
    check("emptyrw.unf", 32'(underflow), 32'd1);
    check("emptyrw.wack", 32'(write_ack), 32'd1);
    check("emptyrw.rvalid", 32'(rdata_valid), 32'd0);

    // Flush at level 7 with a concurrent write
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wdata_valid = 1'b1; write_data = 16'(16'h0400 + i);
      tick();
    end
    check("flush7.pre_level", 32'(fill_level), 32'd7);
    flush = 1'b1; write_data = 16'h04FF;
    tick();
    flush = 1'b0; wdata_valid = 1'b0;
    check("flush7.level", 32'(fill_level), 32'd0);
    check("flush7.empty", 32'(fifo_empty), 32'd1);
    check("flush7.aempty", 32'(fifo_aempty), 32'd1);
    check("flush7.afull", 32'(fifo_afull), 32'd0);
    check("flush7.wack", 32'(write_ack), 32'd0);
    check("flush7.unf", 32'(underflow), 32'd0);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) begin
      wdata_valid = 1'b1; write_data = 16'(16'h0500 + i);
      tick();
    end
    read_req = 1'b1;
    tick();
    check("burst.rvalid", 32'(rdata_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; wdata_valid = 1'b0; read_req = 1'b0;
    check_reset_state("midreset");
    tick();
    check("midreset.stays_empty", 32'(fill_level), 32'd0);

    // Fall-through instance
    f_wvalid = 1'b1; f_wdata = 16'hA5A5;
    tick();
    f_wvalid = 1'b0;
    check("fwft.wack", 32'(f_wack), 32'd1);
    check("fwft.rvalid", 32'(f_rvalid), 32'd1);
    check("fwft.data", 32'(f_rdata), 32'hA5A5);
    check("fwft.empty_pre", 32'(f_empty), 32'd0);
    f_wvalid = 1'b1; f_wdata = 16'h5A5A;
    tick();
    f_wvalid = 1'b0;
    check("fwft.head_held", 32'(f_rdata), 32'hA5A5);
    f_rreq = 1'b1;
    tick();
    check("fwft.next_word", 32'(f_rdata), 32'h5A5A);
    check("fwft.level1", 32'(f_level), 32'd1);
    tick();
    f_rreq = 1'b0;
    check("fwft.empty_post", 32'(f_empty), 32'd1);
    check("fwft.rvalid_post", 32'(f_rvalid), 32'd0);
    check("fwft.unf", 32'(f_unf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
